// File: rtl/frame_mem_arbiter.sv
// Frame-buffer arbiter: fixed-latency VGA reads win the single-port RAM,
// camera writes are queued in a small FIFO and drained into idle slots.
module frame_mem_arbiter #(
  parameter int IMG_W      = 320,
  parameter int IMG_H      = 240,
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 4,
  parameter int FIFO_DEPTH = 8,
  localparam int PTR_W     = $clog2(FIFO_DEPTH),
  localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              pixel_clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [9:0]        rd_x,
  input  logic [8:0]        rd_y,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [9:0]        wr_x,
  input  logic [8:0]        wr_y,
  input  logic [DATA_W-1:0] wr_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [LVL_W-1:0]  fifo_level,
  output logic [15:0]       wr_stall_cnt,
  output logic [15:0]       wr_drop_cnt
);

  logic [ADDR_W-1:0] rd_addr;
  logic              rd_inr;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_inr;

  assign rd_addr = ADDR_W'(rd_y) * ADDR_W'(IMG_W) + ADDR_W'(rd_x);
  assign rd_inr  = (32'(rd_x) < IMG_W) && (32'(rd_y) < IMG_H);
  assign wr_addr = ADDR_W'(wr_y) * ADDR_W'(IMG_W) + ADDR_W'(wr_x);
  assign wr_inr  = (32'(wr_x) < IMG_W) && (32'(wr_y) < IMG_H);

  logic              s1_valid;
  logic              s1_inr;
  logic [ADDR_W-1:0] s1_addr;
  logic              s2_valid;
  logic              s2_inr;

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_inr   <= 1'b0;
      s1_addr  <= '0;
      s2_valid <= 1'b0;
      s2_inr   <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      s1_valid <= rd_en;
      s1_inr   <= rd_inr;
      s1_addr  <= rd_addr;
      s2_valid <= s1_valid;
      s2_inr   <= s1_inr;
      rd_valid <= s2_valid;
      if (s2_valid)
        rd_data <= s2_inr ? mem_rdata : '0;
    end
  end

  logic [ADDR_W-1:0] f_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] f_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  wptr;
  logic [PTR_W-1:0]  rptr;
  logic              push;
  logic              store;
  logic              rd_grant;
  logic              pop;

  assign wr_ready = (fifo_level != LVL_W'(FIFO_DEPTH)) && !rst;
  assign push     = wr_valid && wr_ready;
  assign store    = push && wr_inr;
  assign rd_grant = s1_valid && s1_inr;
  // an out-of-range read leaves its RAM slot free for the FIFO head
  assign pop      = !rd_grant && (fifo_level != '0);

  always_ff @(posedge pixel_clk) begin
    if (store) begin
      f_addr[wptr] <= wr_addr;
      f_data[wptr] <= wr_data;
    end
  end

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_level <= '0;
    end else begin
      if (store)
        wptr <= wptr + PTR_W'(1);
      if (pop)
        rptr <= rptr + PTR_W'(1);
      fifo_level <= fifo_level + LVL_W'(store) - LVL_W'(pop);
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (rd_grant) begin
      mem_en   = 1'b1;
      mem_addr = s1_addr;
    end else if (pop) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = f_addr[rptr];
      mem_wdata = f_data[rptr];
    end
  end

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      wr_stall_cnt <= '0;
      wr_drop_cnt  <= '0;
    end else begin
      if (wr_valid && !wr_ready && wr_stall_cnt != 16'hFFFF)
        wr_stall_cnt <= wr_stall_cnt + 16'd1;
      if (push && !wr_inr && wr_drop_cnt != 16'hFFFF)
        wr_drop_cnt <= wr_drop_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_frame_mem_arbiter.sv
// Directed bench for frame_mem_arbiter with a behavioural
// single-port synchronous RAM attached to the memory port.
module tb_frame_mem_arbiter;

  logic        pixel_clk;
  logic        rst;
  logic        rd_en;
  logic [9:0]  rd_x;
  logic [8:0]  rd_y;
  logic        rd_valid;
  logic [3:0]  rd_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [9:0]  wr_x;
  logic [8:0]  wr_y;
  logic [3:0]  wr_data;
  logic        mem_en;
  logic        mem_we;
  logic [16:0] mem_addr;
  logic [3:0]  mem_wdata;
  logic [3:0]  mem_rdata;
  logic [3:0]  fifo_level;
  logic [15:0] wr_stall_cnt;
  logic [15:0] wr_drop_cnt;

  int checks;
  int errors;

  logic [3:0]  ram [131072];
  logic        pre_en;
  logic [16:0] pre_addr;
  logic [3:0]  pre_data;

  frame_mem_arbiter dut (
    .pixel_clk    (pixel_clk),
    .rst          (rst),
    .rd_en        (rd_en),
    .rd_x         (rd_x),
    .rd_y         (rd_y),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_x         (wr_x),
    .wr_y         (wr_y),
    .wr_data      (wr_data),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .fifo_level   (fifo_level),
    .wr_stall_cnt (wr_stall_cnt),
    .wr_drop_cnt  (wr_drop_cnt)
  );

  initial pixel_clk = 1'b0;
  always #5 pixel_clk = ~pixel_clk;

  always @(posedge pixel_clk) begin
    if (pre_en)
      ram[pre_addr] <= pre_data;
    else if (mem_en && mem_we)
      ram[mem_addr] <= mem_wdata;
    else if (mem_en)
      mem_rdata <= ram[mem_addr];
  end

  task automatic step();
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    rd_en    = 1'b0;
    rd_x     = '0;
    rd_y     = '0;
    wr_valid = 1'b0;
    wr_x     = '0;
    wr_y     = '0;
    wr_data  = '0;
    mem_rdata = '0;
    pre_en   = 1'b1;
    pre_addr = 17'd3205;
    pre_data = 4'hA;

    // reset state
    step();
    step();
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_level", fifo_level, 0);
    check("rst_wr_ready", wr_ready, 0);
    rst    = 1'b0;
    pre_en = 1'b0;
    step();
    check("post_rst_wr_ready", wr_ready, 1);
    check("post_rst_stall", wr_stall_cnt, 0);

    // read latency
    rd_en = 1'b1; rd_x = 10'd5; rd_y = 9'd10;
    step();
    rd_en = 1'b0;
    check("lat_mem_en", mem_en, 1);
    check("lat_mem_we", mem_we, 0);
    check("lat_mem_addr", mem_addr, 3205);
    step();
    check("lat_t2_valid", rd_valid, 0);
    step();
    check("lat_t3_valid", rd_valid, 1);
    check("lat_t3_data", rd_data, 4'hA);
    step();
    check("lat_t4_valid", rd_valid, 0);
    check("lat_t4_hold", rd_data, 4'hA);

    // read priority: writes queue while reads hold the RAM
    rd_en = 1'b1; rd_x = 10'd5; rd_y = 9'd10;
    wr_valid = 1'b1; wr_x = 10'd50; wr_y = 9'd7; wr_data = 4'd0;
    for (int i = 0; i < 20; i++) begin
      logic acc;
      acc = wr_valid && wr_ready;
      step();
      if (acc) wr_data = wr_data + 4'd1;
      check("prio_no_we", mem_en && mem_we, 0);
    end
    rd_en = 1'b0;
    wr_valid = 1'b0;
    check("prio_level", fifo_level, 8);
    check("prio_wr_ready", wr_ready, 0);
    check("prio_stall", wr_stall_cnt, 12);
    check("prio_last_read_we", mem_we, 0);
    for (int j = 0; j < 8; j++) begin
      step();
      check("drain_we", mem_en && mem_we, 1);
      check("drain_addr", mem_addr, 2290);
      check("drain_data", mem_wdata, j);
    end
    step();
    check("drain_done_en", mem_en, 0);
    check("drain_done_level", fifo_level, 0);

    // out-of-range read shares its slot with a pending write
    rd_en = 1'b1; rd_x = 10'd320; rd_y = 9'd0;
    wr_valid = 1'b1; wr_x = 10'd3; wr_y = 9'd3; wr_data = 4'd5;
    step();
    rd_en = 1'b0;
    wr_valid = 1'b0;
    check("oor_rd_slot_we", mem_en && mem_we, 1);
    check("oor_rd_slot_addr", mem_addr, 963);
    check("oor_rd_slot_data", mem_wdata, 5);
    step();
    step();
    check("oor_rd_valid", rd_valid, 1);
    check("oor_rd_data", rd_data, 0);

    // out-of-range write is accepted and dropped
    wr_valid = 1'b1; wr_x = 10'd0; wr_y = 9'd240; wr_data = 4'hF;
    check("oor_wr_ready", wr_ready, 1);
    step();
    wr_valid = 1'b0;
    check("oor_wr_drop", wr_drop_cnt, 1);
    check("oor_wr_level", fifo_level, 0);
    check("oor_wr_mem_en", mem_en, 0);

    // ordering of writes to one address
    wr_valid = 1'b1; wr_x = 10'd1; wr_y = 9'd1; wr_data = 4'd3;
    step();
    wr_data = 4'd7;
    step();
    wr_valid = 1'b0;
    step();
    step();
    rd_en = 1'b1; rd_x = 10'd1; rd_y = 9'd1;
    step();
    rd_en = 1'b0;
    step();
    step();
    check("order_valid", rd_valid, 1);
    check("order_data", rd_data, 7);

    // reset mid-stream
    rd_en = 1'b1; rd_x = 10'd1; rd_y = 9'd1;
    wr_valid = 1'b1; wr_x = 10'd4; wr_y = 9'd4; wr_data = 4'd9;
    repeat (5) step();
    check("mid_level", fifo_level, 5);
    check("mid_rd_data", rd_data, 7);
    rst = 1'b1;
    rd_en = 1'b0;
    wr_valid = 1'b0;
    #1;
    check("mid_rst_rd_valid", rd_valid, 0);
    check("mid_rst_rd_data", rd_data, 0);
    check("mid_rst_mem_en", mem_en, 0);
    check("mid_rst_mem_we", mem_we, 0);
    check("mid_rst_mem_addr", mem_addr, 0);
    check("mid_rst_mem_wdata", mem_wdata, 0);
    check("mid_rst_level", fifo_level, 0);
    check("mid_rst_wr_ready", wr_ready, 0);
    check("mid_rst_drop", wr_drop_cnt, 0);
    step();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      check("after_rst_rd_valid", rd_valid, 0);
      check("after_rst_mem_en", mem_en, 0);
    end
    check("after_rst_level", fifo_level, 0);
    check("after_rst_wr_ready", wr_ready, 1);

    // stall counter saturation
    rd_en = 1'b1; rd_x = 10'd1; rd_y = 9'd1;
    wr_valid = 1'b1; wr_x = 10'd9; wr_y = 9'd9; wr_data = 4'd1;
    for (int n = 0; n < 70000 && wr_stall_cnt != 16'hFFFF; n++)
      step();
    check("sat_reach", wr_stall_cnt, 16'hFFFF);
    repeat (3) step();
    check("sat_hold", wr_stall_cnt, 16'hFFFF);
    check("sat_level", fifo_level, 8);
    rd_en = 1'b0;
    wr_valid = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
